// File: rtl/key_cmd_if.sv
// Handshake bundle between the key debouncers / game logic and the command queue.
interface key_cmd_if;
    logic       frame_tick;
    logic       press_left;
    logic       press_right;
    logic       press_rot;
    logic       press_drop;
    logic       hold_left;
    logic       hold_right;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic       cmd_ready;
    logic       merge_flag;

    modport master (
        output frame_tick, press_left, press_right, press_rot, press_drop,
        output hold_left, hold_right, cmd_ready,
        input  cmd_valid, cmd_code, merge_flag
    );

    modport slave (
        input  frame_tick, press_left, press_right, press_rot, press_drop,
        input  hold_left, hold_right, cmd_ready,
        output cmd_valid, cmd_code, merge_flag
    );
endinterface

// File: rtl/key_cmd_queue.sv
// Tetris key command stage: left/right auto-repeat, pending-bit arbitration
// (drop > rot > left > right) and a small command FIFO with a registered head.
module key_cmd_queue #(
    parameter int DEPTH        = 4,
    parameter int REPEAT_DELAY = 16,
    parameter int REPEAT_RATE  = 4
) (
    input  logic     clk,
    input  logic     rst,
    key_cmd_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_COUNT  = CW'(1);

    logic [1:0]    press_lr;
    logic [1:0]    hold_lr;
    logic [1:0]    repeat_ev;
    logic [3:0]    ev;

    logic [3:0]    pend_reg, pend_next;
    logic [3:0]    sel, clr;
    logic [2:0]    push_code;
    logic          merge_reg, merge_hit;

    logic [2:0]    mem [DEPTH];
    logic [PW-1:0] rd_ptr_reg, wr_ptr_reg, rd_ptr_inc;
    logic [CW-1:0] count_reg, count_next;
    logic [2:0]    head_reg, head_next;
    logic          valid_reg;
    logic          full, pop, push;

    assign press_lr = {bus.press_right, bus.press_left};
    assign hold_lr  = {bus.hold_right, bus.hold_left};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rep
            logic       ra_reg;
            logic [7:0] rc_reg;

            // A press pulse restarts the delay even when a frame tick coincides.
            assign repeat_ev[gi] = ra_reg && hold_lr[gi] && bus.frame_tick &&
                                   !press_lr[gi] && (rc_reg == 8'd1);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ra_reg <= 1'b0;
                    rc_reg <= 8'd0;
                end else if (press_lr[gi]) begin
                    ra_reg <= 1'b1;
                    rc_reg <= 8'(REPEAT_DELAY);
                end else if (ra_reg && !hold_lr[gi]) begin
                    ra_reg <= 1'b0;
                    rc_reg <= 8'd0;
                end else if (ra_reg && bus.frame_tick) begin
                    rc_reg <= (rc_reg == 8'd1) ? 8'(REPEAT_RATE) : rc_reg - 8'd1;
                end
            end
        end
    endgenerate

    assign ev = {bus.press_drop, bus.press_rot,
                 bus.press_right | repeat_ev[1], bus.press_left | repeat_ev[0]};

    always_comb begin
        sel       = 4'b0000;
        push_code = 3'd0;
        if (pend_reg[3]) begin
            sel       = 4'b1000;
            push_code = 3'd4;
        end else if (pend_reg[2]) begin
            sel       = 4'b0100;
            push_code = 3'd3;
        end else if (pend_reg[0]) begin
            sel       = 4'b0001;
            push_code = 3'd1;
        end else if (pend_reg[1]) begin
            sel       = 4'b0010;
            push_code = 3'd2;
        end
    end

    assign full = (count_reg == FULL_COUNT);
    assign pop  = valid_reg && bus.cmd_ready;
    assign push = (|pend_reg) && (!full || pop);
    assign clr  = push ? sel : 4'b0000;

    // An event on the bit being cleared re-arms it rather than merging.
    assign pend_next  = (pend_reg & ~clr) | ev;
    assign merge_hit  = |(ev & pend_reg & ~clr);
    assign rd_ptr_inc = rd_ptr_reg + PW'(1);

    always_comb begin
        count_next = count_reg;
        if (push && !pop)
            count_next = count_reg + ONE_COUNT;
        else if (pop && !push)
            count_next = count_reg - ONE_COUNT;
    end

    // Head register: loads straight from the push when the queue is (becoming)
    // empty, otherwise from the entry behind the one being popped.
    always_comb begin
        head_next = head_reg;
        if ((count_reg == '0) || (pop && (count_reg == ONE_COUNT)))
            head_next = push ? push_code : 3'd0;
        else if (pop)
            head_next = mem[rd_ptr_inc];
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= push_code;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_reg   <= 4'b0000;
            merge_reg  <= 1'b0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= 3'd0;
            valid_reg  <= 1'b0;
        end else begin
            pend_reg  <= pend_next;
            if (merge_hit)
                merge_reg <= 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_inc;
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            count_reg <= count_next;
            head_reg  <= head_next;
            valid_reg <= (count_next != '0);
        end
    end

    assign bus.cmd_valid  = valid_reg;
    assign bus.cmd_code   = head_reg;
    assign bus.merge_flag = merge_reg;
endmodule
